// File: rtl/stream_transpose_ctrl_pkg.sv
// Shared constants and types for the streaming transpose controller.
package stream_transpose_pkg;

    localparam int unsigned NUM_BANKS = 2;

    typedef logic [1:0] bank_count_t;

    // Bit width needed to hold 0..value-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_transpose_ctrl_if.sv
// Handshake and datapath-control bundle of the transpose controller.
interface stream_transpose_ctrl_if
    import stream_transpose_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned GROUP = 4
);
    localparam int unsigned NUM_GROUPS = N / GROUP;
    localparam int unsigned CNT_W      = clog2_min1(N);

    logic                  clk_en;
    logic                  in_valid;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic                  shift_down_en;
    logic                  shift_up_en;
    logic                  timestamp_down;
    logic                  timestamp_up;
    logic [CNT_W-1:0]      wr_row;
    logic [CNT_W-1:0]      rd_col;
    logic [NUM_GROUPS-1:0] addr_grp_sel;
    bank_count_t           bank_count;

    // Controller side.
    modport master (
        input  clk_en, in_valid, out_ready,
        output in_ready, out_valid, shift_down_en, shift_up_en, timestamp_down,
               timestamp_up, wr_row, rd_col, addr_grp_sel, bank_count
    );

    // Stream source/sink and datapath side.
    modport slave (
        output clk_en, in_valid, out_ready,
        input  in_ready, out_valid, shift_down_en, shift_up_en, timestamp_down,
               timestamp_up, wr_row, rd_col, addr_grp_sel, bank_count
    );

endinterface

// File: rtl/stream_transpose_beat_counter.sv
// Modulo-MAX beat counter with a wrap pulse on the increment that returns to zero.
module stream_transpose_beat_counter
    import stream_transpose_pkg::*;
#(
    parameter  int unsigned MAX = 4,
    localparam int unsigned W   = clog2_min1(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q, count_d;

    assign wrap_o  = inc_i && (count_q == W'(MAX - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stream_transpose_ctrl.sv
// Double-buffered control for an N x N streaming transpose: one bank fills by rows
// while the other drains by columns, with valid/ready flow control on both sides.
module stream_transpose_ctrl
    import stream_transpose_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned GROUP = 4
) (
    input logic                   clk,
    input logic                   reset,
    stream_transpose_ctrl_if.master bus
);

    localparam int unsigned NUM_GROUPS = N / GROUP;
    localparam int unsigned IGRP_W     = clog2_min1(GROUP);
    localparam int unsigned GRP_W      = clog2_min1(NUM_GROUPS);

    logic                  wb, rb;
    logic                  wr_done, rd_done;
    logic                  igrp_wrap, grp_wrap;
    logic [IGRP_W-1:0]     igrp_cnt;
    logic [GRP_W-1:0]      grp_cnt, grp_next;
    bank_count_t           bank_count_q, bank_count_d;
    logic                  ts_down_q, ts_up_q;
    logic [NUM_GROUPS-1:0] grp_sel_q, grp_sel_d;
    logic                  unused_igrp_cnt;

    assign bus.in_ready      = bus.clk_en && (bank_count_q != 2'(NUM_BANKS));
    assign bus.out_valid     = bus.clk_en && (bank_count_q != '0);
    assign wb                = bus.in_valid && bus.in_ready;
    assign rb                = bus.out_valid && bus.out_ready;
    assign bus.shift_down_en = wb;
    assign bus.shift_up_en   = rb;
    assign bus.timestamp_down = ts_down_q;
    assign bus.timestamp_up   = ts_up_q;
    assign bus.bank_count     = bank_count_q;
    assign bus.addr_grp_sel   = grp_sel_q;
    assign unused_igrp_cnt    = ^igrp_cnt;

    stream_transpose_beat_counter #(.MAX(N)) u_wr_row (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (wb),
        .count_o(bus.wr_row),
        .wrap_o (wr_done)
    );

    stream_transpose_beat_counter #(.MAX(N)) u_rd_col (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (rb),
        .count_o(bus.rd_col),
        .wrap_o (rd_done)
    );

    stream_transpose_beat_counter #(.MAX(GROUP)) u_in_grp (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (rb),
        .count_o(igrp_cnt),
        .wrap_o (igrp_wrap)
    );

    // Group index and rd_col wrap on the same beat since N is a multiple of GROUP.
    stream_transpose_beat_counter #(.MAX(NUM_GROUPS)) u_grp (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (igrp_wrap),
        .count_o(grp_cnt),
        .wrap_o (grp_wrap)
    );

    always_comb begin
        grp_next = grp_cnt;
        if (grp_wrap) begin
            grp_next = '0;
        end else if (igrp_wrap) begin
            grp_next = grp_cnt + GRP_W'(1);
        end

        bank_count_d = bank_count_q;
        if (wr_done && !rd_done) begin
            bank_count_d = bank_count_q + 2'd1;
        end else if (rd_done && !wr_done) begin
            bank_count_d = bank_count_q - 2'd1;
        end

        // Select follows the group of the upcoming rd_col, blanked while nothing is full.
        grp_sel_d = '0;
        for (int i = 0; i < int'(NUM_GROUPS); i++) begin
            grp_sel_d[i] = (bank_count_d != '0) && (grp_next == GRP_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_down_q    <= 1'b0;
            ts_up_q      <= 1'b0;
            bank_count_q <= '0;
            grp_sel_q    <= '0;
        end else if (bus.clk_en) begin
            if (wr_done) ts_down_q <= ~ts_down_q;
            if (rd_done) ts_up_q   <= ~ts_up_q;
            bank_count_q <= bank_count_d;
            grp_sel_q    <= grp_sel_d;
        end
    end

endmodule

// File: doc/stream_transpose_ctrl.md
Name: stream_transpose_ctrl

Overview:
Parametrised, double-buffered control FSM for the streaming N x N matrix transpose array. It accepts N row beats into one bank ("shift down") while the other bank drains N column beats ("shift up"). It issues the datapath shift enables, the per-bank timestamps (ping-pong pointers) and a one-hot row-group select for the column read-out. It generalises the fixed 32-row, 4-row-group controller to any N/GROUP and adds valid/ready flow control on both sides.

Parameters:
N, 32, matrix dimension (rows = columns = beats per bank); N >= 2
GROUP, 4, rows per address group; N % GROUP == 0, GROUP >= 1
NUM_GROUPS, N/GROUP, derived localparam: width of group-select vector
CNT_W, max(1,$clog2(N)), derived localparam: beat counter width

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
clk_en  in  1  clock enable; no state changes when 0
in_valid  in  1  upstream row beat available
in_ready  out  1  controller can accept a row beat
out_valid  out  1  a full bank is available to drain
out_ready  in  1  downstream accepts a column beat
shift_down_en  out  1  datapath write-shift strobe (= accepted input beat)
shift_up_en  out  1  datapath read-shift strobe (= accepted output beat)
timestamp_down  out  1  bank currently being written
timestamp_up  out  1  bank currently being read
wr_row  out  CNT_W  index of the next row to be written (0..N-1)
rd_col  out  CNT_W  index of the next column to be read (0..N-1)
addr_grp_sel  out  NUM_GROUPS  one-hot select of the row group holding rd_col
bank_count  out  2  number of full banks (0..2)

Behaviour:
- Reset (async, active-high): wr_row=0, rd_col=0, timestamp_down=0, timestamp_up=0, bank_count=0, addr_grp_sel=0, internal group counters=0. Outputs derived from these: in_ready=clk_en, out_valid=0.
- in_ready = clk_en & (bank_count != 2). out_valid = clk_en & (bank_count != 0). Both are combinational from state.
- Write beat (wb) = in_valid & in_ready. shift_down_en = wb, combinational, same cycle.
- Read beat (rb) = out_valid & out_ready. shift_up_en = rb, combinational, same cycle.
- On wb: wr_row increments. At N-1 it wraps to 0, timestamp_down toggles and the "write done" event fires.
- On rb: rd_col increments and the in-group counter increments. When the in-group counter wraps at GROUP-1, the group index increments. At rd_col == N-1, rd_col and the group index wrap to 0, timestamp_up toggles and the "read done" event fires.
- bank_count is updated on the edge: +1 on write done only, -1 on read done only, unchanged when both occur in the same cycle.
- Latency: out_valid rises the cycle after the beat that completes a bank. in_ready falls the cycle after the second bank completes. in_ready re-rises the cycle after a read done.
- addr_grp_sel is registered. It equals one-hot(group index) whenever the post-update bank_count != 0, otherwise all zero. It therefore always matches the current rd_col's group while out_valid=1.
- No division: group tracking uses a separate in-group counter of width max(1,$clog2(GROUP)).
- GROUP == 1 degenerates to a one-hot of rd_col. GROUP == N gives addr_grp_sel = 1'b1 while a bank is valid.
- clk_en=0: no counter, timestamp or bank_count update. in_ready and out_valid are forced to 0, so no beat is lost.
- Reset mid-bank: partial write/read progress is discarded and every register returns to its reset value. Datapath contents become don't-care.
- Invariant: timestamp_down == timestamp_up XOR (bank_count == 1).

Decomposition:
- Package stream_transpose_pkg: constant NUM_BANKS=2, a localparam-safe clog2 function, and typedef of the 2-bit bank_count.
- One sub-module, stream_transpose_beat_counter. Parameter MAX; inputs clk, reset, inc; outputs count and wrap pulse (inc & count==MAX-1).
- Instantiate it for wr_row, rd_col and the in-group counter. The group index is a fourth instance with MAX=NUM_GROUPS, incremented on the in-group wrap.

Test Plan:
1. Reset then 32 back-to-back in_valid beats, out_ready=0 -> wr_row 0..31 then 0. Timestamp_down 0->1 after beat 32. out_valid=1 next cycle, bank_count=1, addr_grp_sel=8'b0000_0001.
2. Continue with 32 more writes, out_ready=0 -> bank_count=2, in_ready=0 from the next cycle. A 65th in_valid gives no shift_down_en.
3. Drain one bank with out_ready=1 -> addr_grp_sel steps 0x01,0x02,...,0x80 every 4 beats. After 32 beats: timestamp_up=1, bank_count=1, in_ready=1 the next cycle.
4. Steady-state streaming, in_valid=out_ready=1 continuously -> write done and read done coincide every 32 cycles. bank_count stays 1 and the timestamps toggle together.
5. Toggle clk_en=0 for 5 cycles mid-bank (wr_row=10, rd_col=17) -> in_ready=out_valid=0, counters frozen at 10/17, and resume exactly there.
6. Assert reset asynchronously at wr_row=20, rd_col=5 between clock edges -> all outputs reach reset values immediately, with no clock edge needed.
7. Param sweep N=6, GROUP=3 and N=4, GROUP=1 -> addr_grp_sel widths 2 and 4. One-hot stepping every 3 beats and every 1 beat respectively. Write done/read done every 6 and 4 beats.
